vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 1440x900 VGA output stage. Generates horizontal and vertical timing from porch/sync parameters, with programmable sync polarity. Provides pixel coordinates to the draw logic, and delays sync/blanking by DRAW_LATENCY cycles so a pipelined renderer lines up with its colour output. Sits between the game renderer (draw_*) and the board VGA pins (pix_*, hsync, vsync).

---
 rtl/vga_timing_pkg.sv | 56 +++++
 rtl/vga_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 202 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Holds default porch/sync figures for the two supported panel modes,
// the line/frame length helper and the test-pattern bar colour table
// (the bars are only used when VGA_TEST_PATTERN_EN is defined).
package vga_timing_pkg;

    // 1440x900 @ 60 Hz
    localparam int VGA1440_H_ACTIVE = 1440;
    localparam int VGA1440_H_FP     = 80;
    localparam int VGA1440_H_SYNC   = 152;
    localparam int VGA1440_H_BP     = 232;
    localparam int VGA1440_V_ACTIVE = 900;
    localparam int VGA1440_V_FP     = 1;
    localparam int VGA1440_V_SYNC   = 3;
    localparam int VGA1440_V_BP     = 28;

    // 640x480 @ 60 Hz (both syncs active low on real monitors)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // Raw, active-high timing flags carried down the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    // Full line (clocks) or frame (lines) length from its four segments.
    function automatic int total_len(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // On/off state of {r,g,b} for each of the eight colour bars.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            default: rgb = 3'b000; // black
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with asynchronous active-low reset.
// DEPTH = 0 degenerates to a plain wire so callers need no special case.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift the input one stage per clock; reset loads the idle value everywhere.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VAL;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Stage 0: free-running h/v counters. Stage 1: pixel coordinates and
// line/frame pulses for the renderer. Sync/blanking then wait
// DRAW_LATENCY cycles for the renderer pipeline and are registered
// together with the colour in a final output stage.
// Optional build macro: VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces the renderer colour with eight internally generated bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = VGA1440_H_ACTIVE,
    parameter int H_FP         = VGA1440_H_FP,
    parameter int H_SYNC       = VGA1440_H_SYNC,
    parameter int H_BP         = VGA1440_H_BP,
    parameter int V_ACTIVE     = VGA1440_V_ACTIVE,
    parameter int V_FP         = VGA1440_V_FP,
    parameter int V_SYNC       = VGA1440_V_SYNC,
    parameter int V_BP         = VGA1440_V_BP,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int COLOR_W      = 4,
    parameter int H_CNT_W      = 11,
    parameter int V_CNT_W      = 10,
    parameter int DRAW_LATENCY = 0,
    parameter int FCNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [COLOR_W-1:0] draw_r,
    input  logic [COLOR_W-1:0] draw_g,
    input  logic [COLOR_W-1:0] draw_b,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic [H_CNT_W-1:0] curr_x,
    output logic [V_CNT_W-1:0] curr_y,
    output logic               coord_valid,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FCNT_W-1:0]  frame_count
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Segment boundaries at counter width; "LAST" bounds are inclusive so
    // a zero front porch cannot overflow the comparison constant.
    localparam logic [H_CNT_W-1:0] H_LAST      = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_SYNC_END  = H_CNT_W'(H_SYNC);
    localparam logic [H_CNT_W-1:0] H_ACT_START = H_CNT_W'(H_SYNC + H_BP);
    localparam logic [H_CNT_W-1:0] H_ACT_LAST  = H_CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [V_CNT_W-1:0] V_LAST      = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_SYNC_END  = V_CNT_W'(V_SYNC);
    localparam logic [V_CNT_W-1:0] V_ACT_START = V_CNT_W'(V_SYNC + V_BP);
    localparam logic [V_CNT_W-1:0] V_ACT_LAST  = V_CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [H_CNT_W-1:0] hcount;
    logic [V_CNT_W-1:0] vcount;
    logic               h_act;
    logic               v_act;
    sync_bits_t         raw_now;
    sync_bits_t         raw_s1;
    sync_bits_t         raw_d;
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

    // Counter widths must hold a full line and a full frame; latency is bounded.
    always_comb begin
        assert (H_TOTAL <= (1 << H_CNT_W)) else $error("H_TOTAL does not fit in H_CNT_W");
        assert (V_TOTAL <= (1 << V_CNT_W)) else $error("V_TOTAL does not fit in V_CNT_W");
        assert (DRAW_LATENCY >= 0 && DRAW_LATENCY <= 15) else $error("DRAW_LATENCY out of range");
    end

    // Stage 0: horizontal counter wraps each line, vertical advances on that wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // Decode the current counter position into active-high timing flags.
    always_comb begin
        h_act      = (hcount >= H_ACT_START) && (hcount <= H_ACT_LAST);
        v_act      = (vcount >= V_ACT_START) && (vcount <= V_ACT_LAST);
        raw_now.hs = (hcount < H_SYNC_END);
        raw_now.vs = (vcount < V_SYNC_END);
        raw_now.de = h_act && v_act;
    end

    // Stage 1: coordinates, pulses and raw flags; frame counter ticks with frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curr_x      <= '0;
            curr_y      <= '0;
            coord_valid <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            raw_s1      <= '0;
        end else begin
            curr_x      <= raw_now.de ? hcount - H_ACT_START : '0;
            curr_y      <= raw_now.de ? vcount - V_ACT_START : '0;
            coord_valid <= raw_now.de;
            line_start  <= (hcount == '0);
            frame_start <= (hcount == '0) && (vcount == '0);
            raw_s1      <= raw_now;
            if ((hcount == '0) && (vcount == '0)) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Sync/blanking wait for the renderer pipeline; idle value is all deasserted.
    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (DRAW_LATENCY),
        .RESET_VAL (3'b000)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_s1),
        .dout (raw_d)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int                 BAR_W_INT = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [H_CNT_W-1:0] BAR_W     = H_CNT_W'(BAR_W_INT);

    logic [H_CNT_W-1:0] x_d;
    logic [H_CNT_W-1:0] bar_full;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_on;

    // The bar column follows the same delay as the renderer so bars line up with de.
    vga_delay_line #(
        .WIDTH     (H_CNT_W),
        .DEPTH     (DRAW_LATENCY),
        .RESET_VAL ('0)
    ) u_x_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (curr_x),
        .dout (x_d)
    );

    // Pick the colour source: generated bars in test mode, renderer otherwise.
    always_comb begin
        bar_full = x_d / BAR_W;
        bar_idx  = (bar_full > H_CNT_W'(7)) ? 3'd7 : bar_full[2:0];
        bar_on   = bar_rgb(bar_idx);
        if (test_mode) begin
            src_r = {COLOR_W{bar_on[2]}};
            src_g = {COLOR_W{bar_on[1]}};
            src_b = {COLOR_W{bar_on[0]}};
        end else begin
            src_r = draw_r;
            src_g = draw_g;
            src_b = draw_b;
        end
    end
`else
    // Colour always comes straight from the renderer.
    always_comb begin
        src_r = draw_r;
        src_g = draw_g;
        src_b = draw_b;
    end
`endif

    // Output stage: apply sync polarity and blank colour outside the active area.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            pix_r <= '0;
            pix_g <= '0;
            pix_b <= '0;
        end else begin
            hsync <= raw_d.hs ? HS_POL : ~HS_POL;
            vsync <= raw_d.vs ? VS_POL : ~VS_POL;
            de    <= raw_d.de;
            pix_r <= raw_d.de ? src_r : '0;
            pix_g <= raw_d.de ? src_g : '0;
            pix_b <= raw_d.de ? src_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (25 clk x 12 lines) so that
// several whole frames fit in a short run. A renderer model echoes
// curr_x/curr_y through three registers, matching DRAW_LATENCY = 3.
module tb_vga_timing_gen;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HBP = 4;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int HT  = 25;
    localparam int VT  = 12;
    localparam int FRAME = HT * VT;
    localparam int LAT = 3;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int OUT_W = 15;
    localparam int RST_POS = 7 * HT + 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] draw_r = '0;
    logic [3:0] draw_g = '0;
    logic [3:0] draw_b = '0;
    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;
    logic [4:0] curr_x;
    logic [3:0] curr_y;
    logic       coord_valid;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic [1:0] frame_count;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [3:0]       hx[3];
    logic [3:0]       hy[3];

    typedef struct {
        int         k;
        logic [4:0] x;
        logic [3:0] y;
        logic       v;
        logic       ls;
        logic       fs;
    } s1_vec_t;

    typedef struct {
        int         k;
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } out_vec_t;

    typedef struct {
        int         k;
        logic [1:0] fc;
    } fc_vec_t;

    s1_vec_t  s1_tab[9];
    out_vec_t out_tab[5];
    fc_vec_t  fc_tab[6];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .COLOR_W(4),
        .H_CNT_W(5), .V_CNT_W(4), .DRAW_LATENCY(LAT), .FCNT_W(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .draw_r      (draw_r),
        .draw_g      (draw_g),
        .draw_b      (draw_b),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .coord_valid (coord_valid),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at sample %0d: got %0h want %0h", name, k, act, exp);
        end
    endtask

    // Stage-1 expectation for counter position p: {x, y, valid, line_start, frame_start}
    function automatic logic [11:0] exp_s1(input int p);
        int h;
        int v;
        logic act;
        logic [4:0] x;
        logic [3:0] y;
        h = p % HT;
        v = (p / HT) % VT;
        act = (h >= HSW + HBP) && (h < HSW + HBP + HA) && (v >= VSW + VBP) && (v < VSW + VBP + VA);
        x = act ? 5'(h - (HSW + HBP)) : 5'd0;
        y = act ? 4'(v - (VSW + VBP)) : 4'd0;
        return {x, y, act, h == 0, (h == 0) && (v == 0)};
    endfunction

    // Output-stage expectation for counter position p: {hsync, vsync, de, r, g, b}
    function automatic logic [OUT_W-1:0] exp_out(input int p);
        int h;
        int v;
        logic act;
        logic [3:0] x;
        logic [3:0] y;
        h = p % HT;
        v = (p / HT) % VT;
        act = (h >= HSW + HBP) && (h < HSW + HBP + HA) && (v >= VSW + VBP) && (v < VSW + VBP + VA);
        x = act ? 4'(h - (HSW + HBP)) : 4'd0;
        y = act ? 4'(v - (VSW + VBP)) : 4'd0;
        return {(h < HSW) ? HPOL : ~HPOL, (v < VSW) ? VPOL : ~VPOL, act,
                act ? x : 4'h0, act ? ~x : 4'h0, act ? y : 4'h0};
    endfunction

    task automatic clear_renderer();
        for (int i = 0; i < 3; i++) begin
            hx[i] = '0;
            hy[i] = '0;
        end
        draw_r = '0;
        draw_g = '0;
        draw_b = '0;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_out"}, {hsync, vsync, de, pix_r, pix_g, pix_b}, {~HPOL, ~VPOL, 1'b0, 12'h000});
        check({name, "_s1"}, {curr_x, curr_y, coord_valid, line_start, frame_start}, 12'h000);
        check({name, "_fc"}, frame_count, 2'd0);
    endtask

    // One sample point, half a clock after the active edge
    task automatic do_sample();
        logic [OUT_W-1:0] e;
        logic [11:0]      s1;
        logic [1:0]       efc;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("out_sync_pix", {hsync, vsync, de, pix_r, pix_g, pix_b}, e);
        end
        s1 = (k == 0) ? 12'h000 : exp_s1(k - 1);
        check("stage1", {curr_x, curr_y, coord_valid, line_start, frame_start}, s1);
        efc = (k == 0) ? 2'd0 : 2'((k - 1) / FRAME + 1);
        check("frame_count", frame_count, efc);

        for (int i = 0; i < 9; i++) begin
            if (s1_tab[i].k == k) begin
                check("probe_s1", {curr_x, curr_y, coord_valid, line_start, frame_start},
                      {s1_tab[i].x, s1_tab[i].y, s1_tab[i].v, s1_tab[i].ls, s1_tab[i].fs});
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (out_tab[i].k == k) begin
                check("probe_out", {hsync, vsync, de, pix_r, pix_g, pix_b},
                      {out_tab[i].hs, out_tab[i].vs, out_tab[i].de, out_tab[i].r, out_tab[i].g, out_tab[i].b});
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (fc_tab[i].k == k) begin
                check("probe_fc", frame_count, fc_tab[i].fc);
            end
        end

        exp_q.push_back(exp_out(k));

        draw_r = hx[2];
        draw_g = ~hx[2];
        draw_b = hy[2];
        hx[2] = hx[1];
        hx[1] = hx[0];
        hx[0] = curr_x[3:0];
        hy[2] = hy[1];
        hy[1] = hy[0];
        hy[0] = curr_y;
    endtask

    task automatic next_sample();
        @(negedge clk);
        k++;
        do_sample();
    endtask

    // Called on a falling edge: release reset and preload the idle outputs
    task automatic release_reset();
        rst = 1'b1;
        k = 0;
        exp_q.delete();
        for (int i = 0; i < LAT + 2; i++) begin
            exp_q.push_back({~HPOL, ~VPOL, 1'b0, 12'h000});
        end
        do_sample();
    endtask

    initial begin
        s1_tab[0] = '{k: 1,   x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b1, fs: 1'b1};
        s1_tab[1] = '{k: 8,   x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b0, fs: 1'b0};
        s1_tab[2] = '{k: 26,  x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b1, fs: 1'b0};
        s1_tab[3] = '{k: 133, x: 5'd0,  y: 4'd0, v: 1'b1, ls: 1'b0, fs: 1'b0};
        s1_tab[4] = '{k: 148, x: 5'd15, y: 4'd0, v: 1'b1, ls: 1'b0, fs: 1'b0};
        s1_tab[5] = '{k: 149, x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b0, fs: 1'b0};
        s1_tab[6] = '{k: 261, x: 5'd3,  y: 4'd5, v: 1'b1, ls: 1'b0, fs: 1'b0};
        s1_tab[7] = '{k: 286, x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b0, fs: 1'b0};
        s1_tab[8] = '{k: 301, x: 5'd0,  y: 4'd0, v: 1'b0, ls: 1'b1, fs: 1'b1};

        out_tab[0] = '{k: 5,   hs: 1'b0, vs: 1'b1, de: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
        out_tab[1] = '{k: 8,   hs: 1'b1, vs: 1'b1, de: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
        out_tab[2] = '{k: 55,  hs: 1'b0, vs: 1'b0, de: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
        out_tab[3] = '{k: 137, hs: 1'b1, vs: 1'b0, de: 1'b1, r: 4'h0, g: 4'hF, b: 4'h0};
        out_tab[4] = '{k: 265, hs: 1'b1, vs: 1'b0, de: 1'b1, r: 4'h3, g: 4'hC, b: 4'h5};

        fc_tab[0] = '{k: 0,    fc: 2'd0};
        fc_tab[1] = '{k: 1,    fc: 2'd1};
        fc_tab[2] = '{k: 301,  fc: 2'd2};
        fc_tab[3] = '{k: 601,  fc: 2'd3};
        fc_tab[4] = '{k: 901,  fc: 2'd0};
        fc_tab[5] = '{k: 1201, fc: 2'd1};

        clear_renderer();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_init");
        release_reset();
        repeat (5 * FRAME + 20) next_sample();

        // Mid-frame reset while the counters sit inside the active area
        for (int i = 0; i < FRAME && (k % FRAME) != RST_POS; i++) begin
            next_sample();
        end
        check("reset_point", 32'(k % FRAME), 32'(RST_POS));
        #2 rst = 1'b0;
        #1 check_reset_vals("reset_async");
        clear_renderer();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_hold");
        release_reset();
        repeat (FRAME + 10) next_sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
